photo_pixel_fetch: RTL

Upstream feeder for the BMP file writer. It reads one RGB565 frame from the SDRAM frame buffer in fixed-length bursts and buffers the pixels in an internal FIFO. It serves them one pixel per read_req/read_req_ack handshake. Rows are fetched bottom-up (last row first) to match BMP row order.

---
 rtl/photo_pixel_fetch.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/photo_pixel_fetch.sv
// Reads an RGB565 frame bottom-up from the SDRAM frame buffer in bursts into a pixel FIFO
// and serves one pixel per read_req handshake. Define FETCH_RB_SWAP_EN to exchange red/blue.
module photo_pixel_fetch #(
   parameter int IMG_W      = 1024,
   parameter int IMG_H      = 768,
   parameter int BASE_ADDR  = 0,
   parameter int BURST_LEN  = 64,
   parameter int FIFO_DEPTH = 256,
   parameter int ADDR_W     = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic [9:0]        mem_rd_len,
   input  logic              mem_rd_ack,
   input  logic              mem_rd_valid,
   input  logic [15:0]       mem_rd_data,
   input  logic              read_req,
   output logic              read_req_ack,
   output logic [15:0]       photo_data,
   output logic              underflow
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int ROW_W  = $clog2(IMG_H + 1);
   localparam int COL_W  = $clog2(IMG_W + 1);
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [21:0]       TOTAL_BURSTS = 22'(IMG_W * IMG_H / BURST_LEN);
   localparam logic [21:0]       TOTAL_PIX    = 22'(IMG_W * IMG_H);
   localparam logic [CNT_W-1:0]  SPACE_LIMIT  = CNT_W'(FIFO_DEPTH - BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(BURST_LEN - 1);

   typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, DONE} state_t;
   state_t state_reg, state_next;

   logic [ROW_W-1:0]  row_reg;
   logic [COL_W-1:0]  col_reg;
   logic [BEAT_W-1:0] beat_reg;
   logic [21:0]       burst_cnt_reg;
   logic [21:0]       pop_cnt_reg;
   logic [9:0]        wait_cnt_reg;
   logic              busy_reg, done_reg, underflow_reg, ack_reg, served_reg;
   logic [15:0]       photo_data_reg;

   logic [15:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;

   logic              start_go, finish, fifo_wr, fifo_rd, fifo_empty, pending, beat_last;
   logic [15:0]       head, head_out;
   logic [ADDR_W-1:0] addr_calc;

   assign fifo_empty = (count_reg == '0);
   assign fifo_wr    = (state_reg == DATA) && mem_rd_valid;
   assign beat_last  = fifo_wr && (beat_reg == LAST_BEAT);
   assign pending    = read_req && !served_reg;
   assign fifo_rd    = pending && !fifo_empty;
   assign head       = fifo_mem[rd_ptr_reg];

`ifdef FETCH_RB_SWAP_EN
   assign head_out = {head[4:0], head[10:5], head[15:11]};
`else
   assign head_out = head;
`endif

   assign addr_calc = ADDR_W'(BASE_ADDR) + ADDR_W'(row_reg) * ADDR_W'(IMG_W) + ADDR_W'(col_reg);

   assign mem_rd_req   = (state_reg == REQ);
   assign mem_rd_addr  = mem_rd_req ? addr_calc : '0;
   assign mem_rd_len   = mem_rd_req ? 10'(BURST_LEN) : '0;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign read_req_ack = ack_reg;
   assign photo_data   = photo_data_reg;
   assign underflow    = underflow_reg;

   always_comb begin
      state_next = state_reg;
      start_go   = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               start_go   = 1'b1;
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (burst_cnt_reg == TOTAL_BURSTS)
               state_next = DONE;
            else if (count_reg <= SPACE_LIMIT)
               state_next = REQ;
         end
         REQ: begin
            if (mem_rd_ack)
               state_next = DATA;
         end
         DATA: begin
            if (beat_last)
               state_next = CHECK;
         end
         DONE: begin
            if (pop_cnt_reg == TOTAL_PIX) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         row_reg        <= '0;
         col_reg        <= '0;
         beat_reg       <= '0;
         burst_cnt_reg  <= '0;
         pop_cnt_reg    <= '0;
         wait_cnt_reg   <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         underflow_reg  <= 1'b0;
         ack_reg        <= 1'b0;
         served_reg     <= 1'b0;
         photo_data_reg <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
      end else begin
         state_reg <= state_next;
         done_reg  <= finish;

         if (start_go) begin
            row_reg       <= ROW_W'(IMG_H - 1);
            col_reg       <= '0;
            beat_reg      <= '0;
            burst_cnt_reg <= '0;
            busy_reg      <= 1'b1;
         end else begin
            if (finish)
               busy_reg <= 1'b0;
            if (fifo_wr)
               beat_reg <= beat_last ? '0 : beat_reg + BEAT_W'(1);
            // Row order is bottom-up, so a completed row steps the row index down.
            if (beat_last) begin
               burst_cnt_reg <= burst_cnt_reg + 22'd1;
               if (32'(col_reg) + BURST_LEN >= IMG_W) begin
                  col_reg <= '0;
                  row_reg <= row_reg - ROW_W'(1);
               end else begin
                  col_reg <= col_reg + COL_W'(BURST_LEN);
               end
            end
         end

         if (start_go)
            pop_cnt_reg <= '0;
         else if (fifo_rd)
            pop_cnt_reg <= pop_cnt_reg + 22'd1;

         if (start_go || !(pending && fifo_empty))
            wait_cnt_reg <= '0;
         else if (wait_cnt_reg != 10'd1023)
            wait_cnt_reg <= wait_cnt_reg + 10'd1;

         if (start_go)
            underflow_reg <= 1'b0;
         else if (wait_cnt_reg == 10'd1023)
            underflow_reg <= 1'b1;

         // served keeps a held-high read_req from draining more than one pixel.
         ack_reg <= fifo_rd;
         if (!read_req)
            served_reg <= 1'b0;
         else if (fifo_rd)
            served_reg <= 1'b1;
         if (fifo_rd)
            photo_data_reg <= head_out;

         if (fifo_wr)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (fifo_rd)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({fifo_wr, fifo_rd})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr)
         fifo_mem[wr_ptr_reg] <= mem_rd_data;
   end

endmodule
